interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Parametrised NUM_IRQ-channel prioritised interrupt controller with one NMI.
//  Per-channel edge/level mode and mask, priority nesting via in-service bits.
//  Sits between external request pins and the CPU control unit.
//  Presents int_req plus a 16-bit vector address; the CPU acknowledges on
//  interrupt entry (ack) and signals RTI completion (eoi).
// PARAMETERS
//  NUM_IRQ    8         channel count, 1..8; channel 0 = highest priority
//  IRQ_BASE   16'hFFE0  channel i vector = IRQ_BASE + 2*i (low byte address)
//  NMI_VECTOR 16'hFFFA  NMI vector address
//  RST_VECTOR 16'hFFFC  vector output while idle and after reset
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous reset, active low
//  clk_en     in   1        state advances only on clk edges with clk_en=1
//  irq        in   NUM_IRQ  request lines, active high
//  edge_mode  in   NUM_IRQ  1 = rising-edge channel, 0 = level channel
//  mask       in   NUM_IRQ  1 = channel masked
//  nmi        in   1        non-maskable request, rising-edge sensitive
//  iFlag      in   1        CPU interrupt-disable flag (gates all IRQs, not NMI)
//  ack        in   1        CPU entering interrupt service (1-cycle pulse)
//  eoi        in   1        CPU executed RTI (1-cycle pulse)
//  int_req    out  1        interrupt request to CPU
//  vector     out  16       vector address for the current request
//  active_id  out  4        granted source: 0..NUM_IRQ-1 = IRQ, 4'hF = NMI
//  pending    out  NUM_IRQ  registered pending bits (debug/status)
//  wak        out  1        wake from WAIT; combinational
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - Clears pend, isr, nmi_pend, nmi_isr and the irq_prev/nmi_prev registers.
//   - FSM=IDLE, int_req=0, vector=RST_VECTOR, active_id=0.
//   - Takes effect immediately, mid-request included.
//  Pending
//   - Edge channel: pend[i] sets on irq[i] 0->1 (prev sampled each enabled cycle).
//     It clears when that channel is acked. A set and a clear in the same cycle: set wins.
//   - Level channel: pend[i] <= irq[i] every enabled cycle, and also clears on ack.
//   - NMI: nmi_pend sets on nmi 0->1 and clears when the NMI is acked. Set wins over clear.
//  Eligibility
//   - elig[i] = pend[i] & ~mask[i] & ~iFlag & (i < highest-priority set isr bit).
//   - No IRQ is eligible while nmi_isr=1.
//   - The NMI is eligible when nmi_pend=1 and nmi_isr=0. The NMI beats all IRQs.
//  FSM (IDLE, REQ, GRANT)
//   - IDLE: if any source is eligible, latch the winner (NMI first, else lowest
//     index) into active_id/vector, go to REQ, and assert int_req next cycle.
//   - REQ: int_req=1; vector and active_id are held stable.
//     Exception: a newly eligible NMI replaces a latched IRQ.
//     A request withdrawn before ack (level deasserted, or mask/iFlag set) is
//     still delivered; no spurious cancel.
//   - REQ and ack=1: clear the granted pending bit, set isr[id] (or nmi_isr),
//     go to GRANT, and drop int_req that cycle.
//   - GRANT: one cycle with int_req=0, then return to IDLE. This lets the CPU
//     push state and set iFlag before re-arbitration.
//   - ack outside REQ is ignored.
//  EOI
//   - eoi clears nmi_isr if it is set; otherwise it clears the lowest-index set isr bit.
//   - eoi with nothing in service is ignored.
//   - eoi and ack in the same cycle: eoi applies to old isr first, then ack's set.
//   - A source still pending after eoi re-requests on the next IDLE evaluation.
//     This includes level IRQ held high after RTI.
//  Nesting
//   - Higher-priority IRQ preempts service if the CPU clears iFlag.
//   - NMI always preempts IRQ service.
//   - NMI edges during NMI service latch and are served after eoi.
//  Wake
//   - wak = int_req | nmi | |(irq & ~mask & ~iFlag).
//   - wak is valid regardless of clk_en.
//  Clock enable
//   - clk_en=0 freezes all registers, including edge-detect history.
// TESTING
//  1. rst_n=0 mid-REQ -> int_req=0, vector=16'hFFFC at once; after release, no request.
//  2. Edge ch3 pulse, ack -> vector=16'hFFE6, active_id=3; ch3 pending clear; no repeat.
//  3. Level ch1 held high through eoi -> int_req re-asserts 2 cycles after GRANT.
//  4. ch5 and ch2 pending simultaneously -> ch2 granted (16'hFFE4); ch5 waits until eoi.
//  5. ch4 in REQ, nmi rises before ack -> vector=16'hFFFA, active_id=4'hF; ch4 stays pending.
//  6. iFlag=1, irq[0]=1 -> int_req=0, wak=0; iFlag=0 -> wak=1 same cycle, int_req next enabled cycle.

Source files
------------

// File: rtl/interrupt_controller.sv
// Prioritised NUM_IRQ-channel interrupt controller with one edge-triggered NMI,
// per-channel edge/level mode and mask, and in-service based priority nesting.
module interrupt_controller #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [15:0] IRQ_BASE   = 16'hFFE0,
    parameter logic [15:0] NMI_VECTOR = 16'hFFFA,
    parameter logic [15:0] RST_VECTOR = 16'hFFFC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] edge_mode,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               nmi,
    input  logic               iFlag,
    input  logic               ack,
    input  logic               eoi,
    output logic               int_req,
    output logic [15:0]        vector,
    output logic [3:0]         active_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               wak
);

    typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;

    localparam logic [3:0] NMI_ID = 4'hF;

    state_t             state_q, state_d;
    logic               int_req_q, int_req_d;
    logic [15:0]        vector_q, vector_d;
    logic [3:0]         active_id_q, active_id_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic               nmi_pend_q, nmi_pend_d;
    logic               nmi_isr_q, nmi_isr_d;
    logic               nmi_prev_q, nmi_prev_d;

    logic [NUM_IRQ-1:0] below_isr;
    logic [NUM_IRQ-1:0] irq_elig;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] isr_after_eoi;
    logic [3:0]         win_idx;
    logic               nmi_elig;
    logic               ack_fire;
    logic               ack_nmi;
    logic               nmi_isr_after_eoi;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        // below_isr[i]: no channel of equal or higher priority is in service.
        below_isr[0] = ~isr_q[0];
        for (int i = 1; i < NUM_IRQ; i++) below_isr[i] = below_isr[i-1] & ~isr_q[i];

        irq_elig = pend_q & ~mask & {NUM_IRQ{~iFlag}} & below_isr & {NUM_IRQ{~nmi_isr_q}};
        nmi_elig = nmi_pend_q & ~nmi_isr_q;

        win_idx = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_elig[i]) win_idx = 4'(i);
        end

        ack_fire = (state_q == REQ) && ack;
        ack_nmi  = ack_fire && (active_id_q == NMI_ID);
        for (int i = 0; i < NUM_IRQ; i++) ack_clr[i] = ack_fire && (active_id_q == 4'(i));

        // Edge channels: a fresh rising edge beats the ack clear. Level channels follow the pin.
        pend_d = (edge_mode & ((pend_q & ~ack_clr) | (irq & ~irq_prev_q)))
               | (~edge_mode & irq & ~ack_clr);
        nmi_pend_d = (nmi_pend_q & ~ack_nmi) | (nmi & ~nmi_prev_q);
        irq_prev_d = irq;
        nmi_prev_d = nmi;

        // EOI retires the NMI first, otherwise the lowest set isr bit; ack then sets its bit.
        isr_after_eoi     = isr_q;
        nmi_isr_after_eoi = nmi_isr_q;
        if (eoi) begin
            if (nmi_isr_q) nmi_isr_after_eoi = 1'b0;
            else           isr_after_eoi     = isr_q & (isr_q - NUM_IRQ'(1));
        end
        isr_d     = isr_after_eoi | ack_clr;
        nmi_isr_d = nmi_isr_after_eoi | ack_nmi;

        state_d     = state_q;
        int_req_d   = int_req_q;
        vector_d    = vector_q;
        active_id_d = active_id_q;
        case (state_q)
            IDLE: begin
                if (nmi_elig) begin
                    state_d     = REQ;
                    int_req_d   = 1'b1;
                    active_id_d = NMI_ID;
                    vector_d    = NMI_VECTOR;
                end else if (|irq_elig) begin
                    state_d     = REQ;
                    int_req_d   = 1'b1;
                    active_id_d = win_idx;
                    vector_d    = IRQ_BASE + {11'd0, win_idx, 1'b0};
                end
            end
            REQ: begin
                if (ack) begin
                    state_d   = GRANT;
                    int_req_d = 1'b0;
                end else if (nmi_elig && active_id_q != NMI_ID) begin
                    active_id_d = NMI_ID;
                    vector_d    = NMI_VECTOR;
                end
            end
            GRANT: begin
                state_d  = IDLE;
                vector_d = RST_VECTOR;
            end
            default: begin
                state_d   = IDLE;
                int_req_d = 1'b0;
                vector_d  = RST_VECTOR;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            int_req_q   <= 1'b0;
            vector_q    <= RST_VECTOR;
            active_id_q <= 4'd0;
            pend_q      <= '0;
            isr_q       <= '0;
            irq_prev_q  <= '0;
            nmi_pend_q  <= 1'b0;
            nmi_isr_q   <= 1'b0;
            nmi_prev_q  <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            int_req_q   <= int_req_d;
            vector_q    <= vector_d;
            active_id_q <= active_id_d;
            pend_q      <= pend_d;
            isr_q       <= isr_d;
            irq_prev_q  <= irq_prev_d;
            nmi_pend_q  <= nmi_pend_d;
            nmi_isr_q   <= nmi_isr_d;
            nmi_prev_q  <= nmi_prev_d;
        end
    end

    assign int_req   = int_req_q;
    assign vector    = vector_q;
    assign active_id = active_id_q;
    assign pending   = pend_q;
    // Wake is combinational so a stopped clock can still be restarted.
    assign wak       = int_req_q | nmi | (|(irq & ~mask & {NUM_IRQ{~iFlag}}));

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus random
// traffic, all compared every cycle against a behavioural model.
module tb_interrupt_controller;

    localparam int NUM = 8;
    localparam logic [15:0] BASE = 16'hFFE0;
    localparam logic [15:0] NMIV = 16'hFFFA;
    localparam logic [15:0] RSTV = 16'hFFFC;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clk_en = 1'b1;
    logic [NUM-1:0] irq = '0, edge_mode = '0, mask = '0;
    logic           nmi = 1'b0, iFlag = 1'b0, ack = 1'b0, eoi = 1'b0;
    logic           int_req, wak;
    logic [15:0]    vector;
    logic [3:0]     active_id;
    logic [NUM-1:0] pending;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    interrupt_controller dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .irq(irq), .edge_mode(edge_mode),
        .mask(mask), .nmi(nmi), .iFlag(iFlag), .ack(ack), .eoi(eoi),
        .int_req(int_req), .vector(vector), .active_id(active_id),
        .pending(pending), .wak(wak)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NUM-1:0] m_pend = '0, m_isr = '0, m_iprev = '0;
    bit             m_npend = 0, m_nisr = 0, m_nprev = 0;
    bit             m_req = 0, m_gap = 0;
    logic [3:0]     m_id = '0;
    logic [15:0]    m_vec = RSTV;

    task automatic model_reset();
        m_pend = '0; m_isr = '0; m_iprev = '0;
        m_npend = 0; m_nisr = 0; m_nprev = 0;
        m_req = 0; m_gap = 0; m_id = '0; m_vec = RSTV;
    endtask

    task automatic model_step();
        int top, best;
        bit nmi_ok, ack_now, clr;
        logic [NUM-1:0] np;
        logic [3:0] g;
        top = NUM;
        for (int i = NUM - 1; i >= 0; i--) if (m_isr[i]) top = i;
        nmi_ok = m_npend && !m_nisr;
        best = -1;
        if (!m_nisr && !iFlag)
            for (int i = 0; i < NUM; i++)
                if (best < 0 && m_pend[i] && !mask[i] && i < top) best = i;
        ack_now = m_req && ack;
        g = m_id;
        for (int i = 0; i < NUM; i++) begin
            clr = ack_now && (g == 4'(i));
            if (edge_mode[i]) np[i] = (m_pend[i] && !clr) || (irq[i] && !m_iprev[i]);
            else              np[i] = irq[i] && !clr;
        end
        m_npend = (m_npend && !(ack_now && g == 4'hF)) || (nmi && !m_nprev);
        if (eoi) begin
            if (m_nisr) m_nisr = 0;
            else if (top < NUM) m_isr[top] = 1'b0;
        end
        if (ack_now) begin
            if (g == 4'hF) m_nisr = 1;
            else m_isr[g[2:0]] = 1'b1;
        end
        if (m_gap) begin
            m_gap = 0; m_vec = RSTV;
        end else if (m_req) begin
            if (ack) begin m_req = 0; m_gap = 1; end
            else if (nmi_ok && g != 4'hF) begin m_id = 4'hF; m_vec = NMIV; end
        end else if (nmi_ok) begin
            m_req = 1; m_id = 4'hF; m_vec = NMIV;
        end else if (best >= 0) begin
            m_req = 1; m_id = best[3:0]; m_vec = BASE + 16'(2 * best);
        end
        m_pend = np; m_iprev = irq; m_nprev = nmi;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else if (clk_en) model_step();
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("int_req", 16'(int_req), 16'(m_req));
            check("vector", vector, m_vec);
            check("active_id", 16'(active_id), 16'(m_id));
            check("pending", 16'(pending), 16'(m_pend));
            check("wak", 16'(wak), 16'(m_req | nmi | (|(irq & ~mask & {NUM{~iFlag}}))));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!int_req && n < 30) begin tick(); n++; end
        check({name, "_req_timeout"}, 16'(int_req), 16'd1);
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        tick(); tick();
        cmp_on = 1'b1;
        #3;
        check("rst_int_req", 16'(int_req), 16'd0);
        check("rst_vector", vector, 16'hFFFC);
        check("rst_active_id", 16'(active_id), 16'd0);
        check("rst_pending", 16'(pending), 16'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a request takes effect immediately.
        edge_mode = 8'hFF;
        irq = 8'h08; tick(); irq = 8'h00;
        wait_req("t1");
        rst_n = 1'b0; #1;
        check("t1_async_int_req", 16'(int_req), 16'd0);
        check("t1_async_vector", vector, 16'hFFFC);
        tick(); rst_n = 1'b1;
        settle(4);
        check("t1_no_req_after", 16'(int_req), 16'd0);

        // Edge channel 3: single delivery.
        irq = 8'h08; tick(); irq = 8'h00;
        wait_req("t2");
        check("t2_vector", vector, 16'hFFE6);
        check("t2_id", 16'(active_id), 16'd3);
        pulse_ack();
        check("t2_grant_int_req", 16'(int_req), 16'd0);
        check("t2_pend_clear", 16'(pending), 16'h0000);
        settle(2); pulse_eoi(); settle(4);
        check("t2_no_repeat", 16'(int_req), 16'd0);

        // Level channel 1 held through RTI re-requests two cycles after GRANT.
        edge_mode = 8'h00;
        irq = 8'h02;
        wait_req("t3");
        check("t3_vector", vector, 16'hFFE2);
        pulse_ack();
        eoi = 1'b1;
        check("t3_grant", 16'(int_req), 16'd0);
        tick(); eoi = 1'b0;
        check("t3_idle", 16'(int_req), 16'd0);
        tick();
        check("t3_rereq", 16'(int_req), 16'd1);
        check("t3_rereq_vec", vector, 16'hFFE2);
        irq = 8'h00;
        pulse_ack(); settle(1); pulse_eoi(); settle(3);

        // Channels 5 and 2 together: 2 wins, 5 waits for eoi.
        edge_mode = 8'hFF;
        irq = 8'h24; tick(); irq = 8'h00;
        wait_req("t4");
        check("t4_vector", vector, 16'hFFE4);
        check("t4_pending_both", 16'(pending), 16'h0024);
        pulse_ack();
        check("t4_pending_5", 16'(pending), 16'h0020);
        settle(4);
        check("t4_ch5_waits", 16'(int_req), 16'd0);
        pulse_eoi();
        wait_req("t4b");
        check("t4_ch5_vector", vector, 16'hFFEA);
        pulse_ack(); settle(1); pulse_eoi(); settle(3);

        // NMI arriving while ch4 is requested replaces it; ch4 stays pending.
        irq = 8'h10; tick(); irq = 8'h00;
        wait_req("t5");
        check("t5_id4", 16'(active_id), 16'd4);
        nmi = 1'b1; tick(); tick(); nmi = 1'b0;
        check("t5_nmi_vector", vector, 16'hFFFA);
        check("t5_nmi_id", 16'(active_id), 16'h000F);
        check("t5_ch4_pending", 16'(pending), 16'h0010);
        pulse_ack(); settle(4);
        check("t5_irq_blocked", 16'(int_req), 16'd0);
        pulse_eoi();
        wait_req("t5b");
        check("t5_ch4_after", 16'(active_id), 16'd4);
        pulse_ack(); settle(1); pulse_eoi(); settle(3);

        // iFlag gating and combinational wake.
        edge_mode = 8'h00; iFlag = 1'b1; irq = 8'h01;
        settle(3);
        check("t6_int_req_off", 16'(int_req), 16'd0);
        check("t6_wak_off", 16'(wak), 16'd0);
        iFlag = 1'b0; #1;
        check("t6_wak_on", 16'(wak), 16'd1);
        check("t6_no_req_yet", 16'(int_req), 16'd0);
        tick();
        check("t6_req_next", 16'(int_req), 16'd1);
        irq = 8'h00;
        pulse_ack(); settle(1); pulse_eoi(); settle(3);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            clk_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) edge_mode = NUM'($urandom);
            if ($urandom_range(0, 49) == 0) mask = NUM'($urandom) & NUM'($urandom);
            for (int i = 0; i < NUM; i++) if ($urandom_range(0, 11) == 0) irq[i] = ~irq[i];
            if ($urandom_range(0, 29) == 0) nmi = ~nmi;
            if ($urandom_range(0, 15) == 0) iFlag = ~iFlag;
            ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            eoi = (m_isr != 0 || m_nisr) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end
        ack = 1'b0; eoi = 1'b0; clk_en = 1'b1;
        settle(2);
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
